// File: rtl/mdu_iterative.sv
// mdu_iterative: RV32M multiply/divide unit, one result bit per cycle, valid/ready handshake
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_mdu_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic             i_kill,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_mdu_data
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_n;
    logic [2:0]       op;
    logic             neg;
    logic [WIDTH-1:0] m, hi, lo;
    logic [CW-1:0]    cnt;

    logic             is_div, sa, sb, div0, ovf, special, accept, last, ge;
    logic [WIDTH-1:0] mag_a, mag_b, spec_res, hi_n, lo_n, q, result;
    logic [WIDTH:0]   sum, sh, diff;
    logic [2*WIDTH-1:0] prod;

    assign is_div   = i_mdu_op[2];
    assign sa       = i_operand_a[WIDTH-1] & (is_div ? ~i_mdu_op[0] : (i_mdu_op[1:0] == 2'b01 || i_mdu_op[1:0] == 2'b10));
    assign sb       = i_operand_b[WIDTH-1] & (is_div ? ~i_mdu_op[0] : (i_mdu_op[1:0] == 2'b01));
    assign mag_a    = sa ? -i_operand_a : i_operand_a;
    assign mag_b    = sb ? -i_operand_b : i_operand_b;
    assign div0     = i_operand_b == '0;
    assign ovf      = ~i_mdu_op[0] & (i_operand_a == {1'b1, {(WIDTH-1){1'b0}}}) & (i_operand_b == '1);
    assign special  = is_div & (div0 | ovf);
    assign spec_res = div0 ? (i_mdu_op[1] ? i_operand_a : '1) : (i_mdu_op[1] ? '0 : i_operand_a);
    assign accept   = (state == IDLE) & i_valid & ~i_kill;
    assign last     = cnt == CW'(WIDTH-1);
    assign o_ready  = state == IDLE;
    assign o_valid  = state == DONE;

    // One iteration: shift-add (hi accumulates, lo shifts out multiplier bits) or restoring divide (hi = remainder, lo = dividend/quotient)
    always_comb begin
        sum    = {1'b0, hi} + {1'b0, (lo[0] ? m : '0)};
        sh     = {hi, lo[WIDTH-1]};
        diff   = sh - {1'b0, m};
        ge     = ~diff[WIDTH];
        hi_n   = op[2] ? (ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0]) : sum[WIDTH:1];
        lo_n   = op[2] ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
        prod   = neg ? -{hi_n, lo_n} : {hi_n, lo_n};
        q      = op[1] ? hi_n : lo_n;
        result = op[2] ? (neg ? -q : q) : (op[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    // Next state; kill beats both drain and accept
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (special ? DONE : CALC) : IDLE;
            CALC:    state_n = i_kill ? IDLE : (last ? DONE : CALC);
            DONE:    state_n = (i_kill | i_ready) ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, iteration and result load (result only changes on entry to DONE)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op         <= '0;
            neg        <= 1'b0;
            m          <= '0;
            hi         <= '0;
            lo         <= '0;
            cnt        <= '0;
            o_mdu_data <= '0;
        end else if (accept) begin
            op  <= i_mdu_op;
            neg <= (i_mdu_op[2] & i_mdu_op[1]) ? sa : sa ^ sb;
            m   <= is_div ? mag_b : mag_a;
            hi  <= '0;
            lo  <= is_div ? mag_a : mag_b;
            cnt <= '0;
            if (special) o_mdu_data <= spec_res;
        end else if (state == CALC) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (last && !i_kill) o_mdu_data <= result;
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed checks of mdu_iterative against an arithmetic reference model
module tb_mdu_iterative;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic         kill = 1'b0;
    logic         rdy = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         o_ready, o_valid;
    logic [W-1:0] data;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];

    mdu_iterative #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
        .i_mdu_op(op), .i_operand_a(a), .i_operand_b(b), .i_kill(kill),
        .o_valid(o_valid), .i_ready(rdy), .o_mdu_data(data)
    );

    always #5 clk = ~clk;

    // Reference: full-width products via sign/zero extension, SV division for the rest
    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] sx, sy, ux, uy, p;
        logic           ov, z;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        ux = {{W{1'b0}}, x};
        uy = {{W{1'b0}}, y};
        z  = y == '0;
        ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ux * uy; return p[W-1:0]; end
            3'd1: begin p = sx * sy; return p[2*W-1:W]; end
            3'd2: begin p = sx * uy; return p[2*W-1:W]; end
            3'd3: begin p = ux * uy; return p[2*W-1:W]; end
            3'd4: return z ? '1 : ov ? x : W'($signed(x) / $signed(y));
            3'd5: return z ? '1 : x / y;
            3'd6: return z ? x : ov ? '0 : W'($signed(x) % $signed(y));
            default: return z ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        return (o[2] && (y == '0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) ? 0 : W;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Compare process: any valid result must match the oldest outstanding model result
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL model: unexpected result %h", data);
            end else if (data !== exp_q[0]) begin
                errors++;
                $display("FAIL model: got %h, want %h", data, exp_q[0]);
            end
            if (rdy && !kill && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    // Issue one op from IDLE (called just after a rising edge), scramble inputs, then drain
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] lit, input bit use_lit, input int hold);
        logic [W-1:0] cap;
        int           n;
        valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        exp_q.push_back(model(o, x, y));
        #1;
        valid = 1'b0; op = ~o; a = ~x; b = y ^ 32'h5A5A_A5A5;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk_int("latency", n, exp_lat(o, x, y));
        if (use_lit) chk("literal", data, lit);
        cap = data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_data", data, cap);
            chk("hold_valid", {31'b0, o_valid}, 1);
            chk("hold_ready", {31'b0, o_ready}, 0);
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        chk("drain_ready", {31'b0, o_ready}, 1);
        chk("drain_valid", {31'b0, o_valid}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        logic [2:0]   ro;
        logic [W-1:0] rx, ry;
        #12;
        chk("reset_ready", {31'b0, o_ready}, 1);
        chk("reset_valid", {31'b0, o_valid}, 0);
        chk("reset_data", data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1, 0);
        run_op(3'd5, 32'd100,       32'd7,         32'd14,        1, 0);
        run_op(3'd7, 32'd100,       32'd7,         32'd2,         1, 0);
        run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op(3'd6, 32'd5,         32'd0,         32'd5,         1, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);
        run_op(3'd4, 32'd12345,     32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op(3'd7, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 0);
        run_op(3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 0);
        run_op(3'd1, 32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 1, 0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'd0,         1, 0);

        // Backpressure in DONE
        run_op(3'd0, 32'h1234_5678, 32'h0000_0100, 32'h3456_7800, 1, 5);

        // Kill at iteration 10
        valid = 1'b1; op = 3'd0; a = 32'd55; b = 32'd66;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_ready", {31'b0, o_ready}, 1);
        chk("kill_valid", {31'b0, o_valid}, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        chk_int("kill_no_valid", seen, 0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 1, 0);

        // Asynchronous reset mid-CALC
        valid = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, o_valid}, 0);
        chk("arst_data", data, 0);
        chk("arst_ready", {31'b0, o_ready}, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(3'd5, 32'd9, 32'd3, 32'd3, 1, 0);

        // Pseudo-random operands, model-checked
        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = (i % 4 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(ro, rx, ry, '0, 0, 0);
        end

        chk_int("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
